// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
package tdm_pkg;

    // Frame-sync FSM states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned NCH_DEF = 4;
    localparam int unsigned DW_DEF  = 8;

    // Channel counter width for a given channel count
    function automatic int unsigned cnt_w(input int unsigned nch);
        return $clog2(nch);
    endfunction

endpackage

// File: rtl/tdm_par_chk.sv
// Even-parity checker: flags a mismatch between the word parity and par_i.
module tdm_par_chk #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] data_i,
    input  logic          par_i,
    output logic          err_c
);

    // Combinational parity compare
    assign err_c = (^data_i) ^ par_i;

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects NCH channel words per frame into a
// shadow bank and publishes complete frames to a registered output bank.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds in_par and parity check).
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned DW  = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_valid,
    input  logic                   in_sof,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                   in_par,
`endif
    output logic [NCH*DW-1:0]      out_data,
    output logic                   out_valid,
    output logic                   frame_err,
    output logic [cnt_w(NCH)-1:0]  ch_idx
);

    localparam int unsigned   CW   = cnt_w(NCH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         shadow_q [NCH];
    logic [DW-1:0]         shadow_d [NCH];
    logic [NCH*DW-1:0]     out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  par_err;

`ifdef TDM_DEMUX_PARITY_EN
    logic par_chk_err;

    tdm_par_chk #(
        .DW (DW)
    ) u_par_chk (
        .data_i (in_data),
        .par_i  (in_par),
        .err_c  (par_chk_err)
    );

    assign par_err = in_valid & par_chk_err;
`else
    assign par_err = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            for (int unsigned k = 0; k < NCH; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    // Next-state: SOF opens a frame, last channel or parity error closes it
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            if (par_err) begin
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: if (in_sof) state_d = RUN;
                    RUN:  if (!in_sof && (cnt_q == LAST)) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Datapath: shadow writes, frame publish, counter and pulse generation
    always_comb begin
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            shadow_d[k] = shadow_q[k];
        end

        if (in_valid) begin
            if (par_err) begin
                frame_err_d = 1'b1;
                cnt_d       = '0;
            end else if (in_sof) begin
                // SOF in RUN is premature: flag it and restart at channel 0
                frame_err_d = (state_q == RUN);
                shadow_d[0] = in_data;
                cnt_d       = CW'(1);
            end else if (state_q == IDLE) begin
                frame_err_d = 1'b1;
            end else begin
                shadow_d[cnt_q] = in_data;
                if (cnt_q == LAST) begin
                    for (int unsigned k = 0; k < NCH; k++) begin
                        out_data_d[k*DW +: DW] = shadow_d[k];
                    end
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign ch_idx    = cnt_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed scoreboard bench for tdm_demux (NCH=4, DW=8).
module tb_tdm_demux;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_sof;
    logic [NCH*DW-1:0] out_data;
    logic              out_valid;
    logic              frame_err;
    logic [CW-1:0]     ch_idx;

`ifdef TDM_DEMUX_PARITY_EN
    logic in_par;
    logic flip_par;
    assign in_par = (^in_data) ^ flip_par;
`endif

    int unsigned       total = 0;
    int unsigned       bad   = 0;
    logic [NCH*DW-1:0] exp_q [$];
    logic [NCH*DW-1:0] last_out;

    always #5 clk = ~clk;

    tdm_demux #(
        .NCH (NCH),
        .DW  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
`ifdef TDM_DEMUX_PARITY_EN
        .in_par    (in_par),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .ch_idx    (ch_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then check the outputs produced by that edge
    task automatic step(input logic v, input logic s, input logic [DW-1:0] d,
                        input logic e_ov, input logic e_fe, input logic [CW-1:0] e_idx,
                        input string tag);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, ".frame_err"}, 64'(frame_err), 64'(e_fe));
        chk({tag, ".ch_idx"}, 64'(ch_idx), 64'(e_idx));
        if (out_valid === 1'b1) begin
            chk({tag, ".sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                last_out = exp_q.pop_front();
                chk({tag, ".out_data"}, 64'(out_data), 64'(last_out));
            end
        end else begin
            chk({tag, ".out_data_hold"}, 64'(out_data), 64'(last_out));
        end
    endtask

    task automatic idle(input int n, input logic [CW-1:0] e_idx, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, e_idx, tag);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        last_out = '0;
`ifdef TDM_DEMUX_PARITY_EN
        flip_par = 1'b0;
`endif
        #12;
        chk("rst.out_data", 64'(out_data), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.frame_err", 64'(frame_err), 64'd0);
        chk("rst.ch_idx", 64'(ch_idx), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal frame
        exp_q.push_back(32'h44332211);
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 2'd1, "nom0");
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 2'd2, "nom1");
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 2'd3, "nom2");
        step(1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 2'd0, "nom3");
        idle(2, 2'd0, "nom_idle");

        // Gapped frame
        exp_q.push_back(32'h44332211);
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 2'd1, "gap0");
        idle(3, 2'd1, "gap_i0");
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 2'd2, "gap1");
        idle(3, 2'd2, "gap_i1");
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 2'd3, "gap2");
        idle(3, 2'd3, "gap_i2");
        step(1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 2'd0, "gap3");
        idle(1, 2'd0, "gap_idle");

        // Premature SOF
        step(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 2'd1, "pre0");
        step(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 2'd2, "pre1");
        exp_q.push_back(32'hB4B3B2B1);
        step(1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 2'd1, "pre_sof");
        step(1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 2'd2, "pre2");
        step(1'b1, 1'b0, 8'hB3, 1'b0, 1'b0, 2'd3, "pre3");
        step(1'b1, 1'b0, 8'hB4, 1'b1, 1'b0, 2'd0, "pre4");

        // Stray word in IDLE, then a good frame
        step(1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 2'd0, "stray");
        exp_q.push_back(32'hDDCCBBAA);
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 2'd1, "st0");
        step(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0, 2'd2, "st1");
        step(1'b1, 1'b0, 8'hCC, 1'b0, 1'b0, 2'd3, "st2");
        step(1'b1, 1'b0, 8'hDD, 1'b1, 1'b0, 2'd0, "st3");

        // Back-to-back frames at full rate
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 2'd1, "bb0");
        step(1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 2'd2, "bb1");
        step(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 2'd3, "bb2");
        step(1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 2'd0, "bb3");
        step(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 2'd1, "bb4");
        step(1'b1, 1'b0, 8'h06, 1'b0, 1'b0, 2'd2, "bb5");
        step(1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 2'd3, "bb6");
        step(1'b1, 1'b0, 8'h08, 1'b1, 1'b0, 2'd0, "bb7");

        // Reset mid-frame
        step(1'b1, 1'b1, 8'h91, 1'b0, 1'b0, 2'd1, "rm0");
        step(1'b1, 1'b0, 8'h92, 1'b0, 1'b0, 2'd2, "rm1");
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rm.out_data", 64'(out_data), 64'd0);
        chk("rm.out_valid", 64'(out_valid), 64'd0);
        chk("rm.frame_err", 64'(frame_err), 64'd0);
        chk("rm.ch_idx", 64'(ch_idx), 64'd0);
        last_out = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(32'hC4C3C2C1);
        step(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0, 2'd1, "ar0");
        step(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0, 2'd2, "ar1");
        step(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 2'd3, "ar2");
        step(1'b1, 1'b0, 8'hC4, 1'b1, 1'b0, 2'd0, "ar3");

`ifdef TDM_DEMUX_PARITY_EN
        // Bad parity on word 2 aborts the frame
        step(1'b1, 1'b1, 8'hE1, 1'b0, 1'b0, 2'd1, "par0");
        flip_par = 1'b1;
        step(1'b1, 1'b0, 8'hE2, 1'b0, 1'b1, 2'd0, "par_bad");
        // Bad parity on a word that is dropped anyway: one pulse
        step(1'b1, 1'b0, 8'hE3, 1'b0, 1'b1, 2'd0, "par_drop");
        // Bad parity on an SOF keeps IDLE
        step(1'b1, 1'b1, 8'hE4, 1'b0, 1'b1, 2'd0, "par_sof");
        flip_par = 1'b0;
        idle(1, 2'd0, "par_idle");
        exp_q.push_back(32'hF4F3F2F1);
        step(1'b1, 1'b1, 8'hF1, 1'b0, 1'b0, 2'd1, "pg0");
        step(1'b1, 1'b0, 8'hF2, 1'b0, 1'b0, 2'd2, "pg1");
        step(1'b1, 1'b0, 8'hF3, 1'b0, 1'b0, 2'd3, "pg2");
        step(1'b1, 1'b0, 8'hF4, 1'b1, 1'b0, 2'd0, "pg3");
`endif

        idle(2, 2'd0, "tail");
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
